// File: rtl/turn_signal_seq_if.sv
// rtl/turn_signal_seq_if.sv - request and lamp signals between the turn-signal sequencer and its controller
interface turn_signal_seq_if #(
    parameter int LAMPS = 3
);
    logic             left_req;
    logic             right_req;
    logic             hazard_req;
    logic             brake;
    logic [LAMPS-1:0] left_lamps;
    logic [LAMPS-1:0] right_lamps;
    logic             busy;

    modport master (
        output left_req, right_req, hazard_req, brake,
        input  left_lamps, right_lamps, busy
    );

    modport slave (
        input  left_req, right_req, hazard_req, brake,
        output left_lamps, right_lamps, busy
    );
endinterface

// File: rtl/turn_signal_seq.sv
// rtl/turn_signal_seq.sv - prescaled chase/flash tail-lamp sequencer with hazard and brake overlay
module turn_signal_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 25_000_000,
    parameter int CHASE    = 1
) (
    input  logic              clock,
    input  logic              reset,
    turn_signal_seq_if.slave  bus
);
    localparam int SW = $clog2(LAMPS + 1);
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF} state_t;

    state_t           state, state_n;
    logic [SW-1:0]    s, s_n, s_inc;
    logic [CW-1:0]    cnt;
    logic             tick;
    logic             dir_left, dir_right;
    logic [LAMPS-1:0] sweep, sweep_rev, sig_l, sig_r, fill;
    logic [LAMPS-1:0] left_n, right_n, left_q, right_q;
    logic             busy_n, busy_q;

    // Free-running prescaler: never restarted by requests, so steps stay phase-locked to reset release.
    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            s       <= '0;
            left_q  <= '0;
            right_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            s       <= s_n;
            left_q  <= left_n;
            right_q <= right_n;
            busy_q  <= busy_n;
        end
    end

    assign dir_left  = bus.left_req & ~bus.right_req;
    assign dir_right = bus.right_req & ~bus.left_req;
    assign s_inc     = (s == SW'(LAMPS)) ? '0 : s + 1'b1;

    always_comb begin
        state_n = state;
        s_n     = s;
        if (tick) begin
            if (bus.hazard_req) begin
                state_n = (state == HAZ_ON) ? HAZ_OFF : HAZ_ON;
                s_n     = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (dir_left)       begin state_n = LEFT;  s_n = SW'(1); end
                        else if (dir_right) begin state_n = RIGHT; s_n = SW'(1); end
                    end
                    LEFT: begin
                        if (dir_right)                  begin state_n = RIGHT; s_n = SW'(1); end
                        else if (!dir_left && s == '0)  state_n = IDLE;
                        else                            s_n = s_inc;
                    end
                    RIGHT: begin
                        if (dir_left)                   begin state_n = LEFT; s_n = SW'(1); end
                        else if (!dir_right && s == '0) state_n = IDLE;
                        else                            s_n = s_inc;
                    end
                    HAZ_ON:  state_n = HAZ_OFF;
                    default: begin state_n = IDLE; s_n = '0; end
                endcase
            end
        end
    end

    // Lamps are computed from the upcoming state so a tick's step shows on the same edge.
    always_comb begin
        sweep     = '0;
        sweep_rev = '0;
        for (int i = 0; i < LAMPS; i++) begin
            sweep[i]             = (SW'(i) < s_n);
            sweep_rev[LAMPS-1-i] = (SW'(i) < s_n);
        end
        sig_l   = (CHASE != 0) ? sweep     : (s_n[0] ? '1 : '0);
        sig_r   = (CHASE != 0) ? sweep_rev : (s_n[0] ? '1 : '0);
        fill    = bus.brake ? '1 : '0;
        left_n  = fill;
        right_n = fill;
        case (state_n)
            LEFT:    left_n = sig_l;
            RIGHT:   right_n = sig_r;
            HAZ_ON:  begin left_n = '1; right_n = '1; end
            HAZ_OFF: begin left_n = '0; right_n = '0; end
            default: ;
        endcase
        busy_n = (state_n != IDLE);
    end

    assign bus.left_lamps  = left_q;
    assign bus.right_lamps = right_q;
    assign bus.busy        = busy_q;
endmodule
